gemm_seq_ctrl: RTL

Sequencer for the combinational gemm_op datapath. It runs a configured loop of GEMM micro-ops. Each iteration issues synchronous reads to the input, weight and accumulator buffers. It then steers the accumulator operand (buffer data or zero) into gemm_op and writes o_tensor back to the accumulator buffer. It sits between the instruction/config front-end and the three tensor SRAMs.

---
 rtl/gemm_seq_ctrl_if.sv | 46 ++++
 rtl/gemm_seq_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/gemm_seq_ctrl_if.sv
// Config/launch inputs and tensor-SRAM strobes between the front-end and the GEMM sequencer.
interface gemm_seq_ctrl_if #(
    parameter int unsigned INP_AW = 11,
    parameter int unsigned WGT_AW = 10,
    parameter int unsigned ACC_AW = 11,
    parameter int unsigned CNT_W  = 14
);
    logic              start;
    logic [CNT_W-1:0]  iter_cnt;
    logic [INP_AW-1:0] inp_base;
    logic [WGT_AW-1:0] wgt_base;
    logic [ACC_AW-1:0] acc_base;
    logic [INP_AW-1:0] inp_step;
    logic [WGT_AW-1:0] wgt_step;
    logic [ACC_AW-1:0] acc_step;
    logic              reset_acc;
    logic              stall;

    logic              inp_rd_en;
    logic [INP_AW-1:0] inp_rd_addr;
    logic              wgt_rd_en;
    logic [WGT_AW-1:0] wgt_rd_addr;
    logic              acc_rd_en;
    logic [ACC_AW-1:0] acc_rd_addr;
    logic              acc_sel;
    logic              acc_wr_en;
    logic [ACC_AW-1:0] acc_wr_addr;
    logic              busy;
    logic              done;

    modport master (
        input  start, iter_cnt, inp_base, wgt_base, acc_base,
               inp_step, wgt_step, acc_step, reset_acc, stall,
        output inp_rd_en, inp_rd_addr, wgt_rd_en, wgt_rd_addr,
               acc_rd_en, acc_rd_addr, acc_sel, acc_wr_en, acc_wr_addr,
               busy, done
    );

    modport slave (
        output start, iter_cnt, inp_base, wgt_base, acc_base,
               inp_step, wgt_step, acc_step, reset_acc, stall,
        input  inp_rd_en, inp_rd_addr, wgt_rd_en, wgt_rd_addr,
               acc_rd_en, acc_rd_addr, acc_sel, acc_wr_en, acc_wr_addr,
               busy, done
    );
endinterface

// File: rtl/gemm_seq_ctrl.sv
// GEMM micro-op sequencer: two-stage issue/writeback loop over input, weight and accumulator SRAMs.
module gemm_seq_ctrl #(
    parameter int unsigned INP_AW = 11,
    parameter int unsigned WGT_AW = 10,
    parameter int unsigned ACC_AW = 11,
    parameter int unsigned CNT_W  = 14
) (
    input  logic           clk,
    input  logic           rst_n,
    gemm_seq_ctrl_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  rem;
    logic [INP_AW-1:0] inp_addr, inp_step_q;
    logic [WGT_AW-1:0] wgt_addr, wgt_step_q;
    logic [ACC_AW-1:0] acc_addr, acc_step_q;
    logic              reset_acc_q;
    logic              wb_vld;
    logic [ACC_AW-1:0] wb_addr;
    logic              busy_q, done_q;

    logic hazard, issue, wb_fire, launch;

    // Read-first accumulator: never read the tile that is being written this cycle.
    assign hazard  = !reset_acc_q && wb_vld && (wb_addr == acc_addr);
    assign issue   = (state == S_RUN) && !bus.stall && !hazard;
    assign wb_fire = wb_vld && !bus.stall;
    assign launch  = (state == S_IDLE) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        bus.inp_rd_en   = 1'b0;
        bus.wgt_rd_en   = 1'b0;
        bus.acc_rd_en   = 1'b0;
        bus.acc_wr_en   = 1'b0;
        bus.acc_sel     = 1'b0;
        bus.inp_rd_addr = inp_addr;
        bus.wgt_rd_addr = wgt_addr;
        bus.acc_rd_addr = acc_addr;
        bus.acc_wr_addr = wb_addr;
        bus.busy        = busy_q;
        bus.done        = done_q;

        case (state)
            S_IDLE:  if (bus.start) state_nxt = (bus.iter_cnt == '0) ? S_DONE : S_RUN;
            S_RUN:   if (issue && (rem == CNT_W'(1))) state_nxt = S_DRAIN;
            S_DRAIN: if (wb_fire) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        bus.inp_rd_en = issue;
        bus.wgt_rd_en = issue;
        bus.acc_rd_en = issue && !reset_acc_q;
        bus.acc_wr_en = wb_fire;
        bus.acc_sel   = wb_vld && !reset_acc_q;
    end

    // busy/done are decoded from the next state so they leave a flop directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt != S_IDLE);
            done_q <= (state_nxt == S_DONE);
        end
    end

    // Config latch, address walk and the single-entry writeback stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem         <= '0;
            inp_addr    <= '0;
            wgt_addr    <= '0;
            acc_addr    <= '0;
            inp_step_q  <= '0;
            wgt_step_q  <= '0;
            acc_step_q  <= '0;
            reset_acc_q <= 1'b0;
            wb_vld      <= 1'b0;
            wb_addr     <= '0;
        end else if (launch) begin
            rem         <= bus.iter_cnt;
            inp_addr    <= bus.inp_base;
            wgt_addr    <= bus.wgt_base;
            acc_addr    <= bus.acc_base;
            inp_step_q  <= bus.inp_step;
            wgt_step_q  <= bus.wgt_step;
            acc_step_q  <= bus.acc_step;
            reset_acc_q <= bus.reset_acc;
            wb_vld      <= 1'b0;
        end else if (issue) begin
            rem      <= CNT_W'(rem - CNT_W'(1));
            inp_addr <= INP_AW'(inp_addr + inp_step_q);
            wgt_addr <= WGT_AW'(wgt_addr + wgt_step_q);
            acc_addr <= ACC_AW'(acc_addr + acc_step_q);
            wb_vld   <= 1'b1;
            wb_addr  <= acc_addr;
        end else if (wb_fire) begin
            wb_vld <= 1'b0;
        end
    end
endmodule
